// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage PC sequencer with held redirects and a halt freeze
module fetch_controller #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_TARGET = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] npc,
  input  logic            ihit,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_target,
  input  logic            halt,
  output logic            PCEN,
  output logic [PC_W-1:0] new_pc,
  output logic            iREN,
  output logic            flush_fd,
  output logic            halted
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pend_target;
  logic            redirect;
  logic [PC_W-1:0] sel_target;
  logic [PC_W-1:0] target;

  assign redirect = branch_taken | jr | jump;

  // Older control-flow instruction wins: branch over jr over jump.
  always_comb begin
    sel_target = jump_target;
    if (branch_taken)
      sel_target = branch_target;
    else if (jr)
      sel_target = jr_target;
  end

  assign target = {sel_target[PC_W-1:2], 2'b00};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      pend_target <= RESET_TARGET;
    end else begin
      case (state)
        RUN: begin
          if (halt)
            state <= HALT;
          else if (redirect && !ihit) begin
            pend_target <= target;
            state       <= PEND;
          end
        end
        PEND: begin
          if (halt)
            state <= HALT;
          else if (ihit)
            state <= RUN;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // Reset gates every output directly so they drop without waiting for a clock.
  always_comb begin
    PCEN     = 1'b0;
    new_pc   = npc;
    iREN     = 1'b0;
    flush_fd = 1'b0;
    halted   = 1'b0;
    if (!RST) begin
      case (state)
        RUN: begin
          iREN = 1'b1;
          if (!halt) begin
            if (redirect) begin
              new_pc   = target;
              PCEN     = ihit;
              flush_fd = ihit;
            end else begin
              PCEN = ihit & ~stall;
            end
          end
        end
        PEND: begin
          iREN   = 1'b1;
          new_pc = pend_target;
          if (!halt) begin
            PCEN     = ihit;
            flush_fd = ihit;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          PCEN = 1'b0;
        end
      endcase
    end
  end

endmodule
